// File: rtl/cast_code_pkg.sv
// rtl/cast_code_pkg.sv - shared types and default constants for the cast code decoder
// Purpose: holds the decoded entry layout and the default match constants.
// Contents: entry_t {sel, is_default, err}; A/B/K2/K3/C default constants.
package cast_code_pkg;

  localparam int A_DEFAULT  = 10;
  localparam int B_DEFAULT  = 12;
  localparam int K2_DEFAULT = 45;
  localparam int K3_DEFAULT = 33;
  localparam int C_DEFAULT  = 16;

  typedef struct packed {
    logic [1:0] sel;
    logic       is_default;
    logic       err;
  } entry_t;

endpackage

// File: rtl/cast_code_fifo.sv
// rtl/cast_code_fifo.sv - synchronous FIFO of decoded entries
// Purpose: DEPTH-entry FIFO, registered flags, no bypass from write to read.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    write request and entry (taken only when in_ready)
//   pop            read request (taken only when out_valid)
//   in_ready       occupancy < DEPTH (registered count only)
//   out_valid      occupancy > 0
//   head           entry at the read pointer
module cast_code_fifo
  import cast_code_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output logic in_ready,
  output logic out_valid,
  output T     head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  T              mem [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push_ok   = push && in_ready;
  assign pop_ok    = pop && out_valid;
  assign head      = mem[rptr];

  // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cast_code_decoder.sv
// rtl/cast_code_decoder.sv - priority code decoder feeding an output FIFO
// Purpose: decodes in_code against truncated constants K0..K3, KD and queues the result.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid, in_code, in_ready       code input handshake
//   out_valid, out_ready              entry output handshake
//   out_sel, out_default, out_err     head entry fields (0 when out_valid = 0)
//   err_count                         saturating count of unmatched pushes
module cast_code_decoder
  import cast_code_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int A     = A_DEFAULT,
  parameter int B     = B_DEFAULT,
  parameter int C     = C_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_code,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_sel,
  output logic             out_default,
  output logic             out_err,
  input  logic             out_ready,
  output logic [7:0]       err_count
);

  localparam logic [WIDTH-1:0] K0 = WIDTH'(A);
  localparam logic [WIDTH-1:0] K1 = WIDTH'(B);
  localparam logic [WIDTH-1:0] K2 = WIDTH'(K2_DEFAULT);
  localparam logic [WIDTH-1:0] K3 = WIDTH'(K3_DEFAULT);
  localparam logic [WIDTH-1:0] KD = WIDTH'(C);

  // Earlier constants win when truncation makes two of them equal.
  function automatic entry_t decode(input logic [WIDTH-1:0] code);
    entry_t e;
    e = '0;
    if      (code == K0) e.sel = 2'd0;
    else if (code == K1) e.sel = 2'd1;
    else if (code == K2) e.sel = 2'd2;
    else if (code == K3) e.sel = 2'd3;
    else if (code == KD) e.is_default = 1'b1;
    else                 e.err = 1'b1;
    return e;
  endfunction

  entry_t dec;
  entry_t head;
  logic   push_fire;

  assign dec       = decode(in_code);
  assign push_fire = in_valid && in_ready;

  cast_code_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .wdata     (dec),
    .pop       (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .head      (head)
  );

  // Gating on out_valid keeps the fields at 0 through reset and while empty.
  assign out_sel     = out_valid ? head.sel        : 2'd0;
  assign out_default = out_valid ? head.is_default : 1'b0;
  assign out_err     = out_valid ? head.err        : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (push_fire && dec.err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_cast_code_decoder.sv
// tb/tb_cast_code_decoder.sv - self-checking bench for cast_code_decoder
module tb_cast_code_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_code = 4'd0;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_sel;
  logic       out_default;
  logic       out_err;
  logic       out_ready = 1'b0;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_fail = 0;
  int n_pops = 0;
  int n_pushes = 0;
  int model_err = 0;
  logic [3:0] sb [$];

  typedef struct {
    logic [3:0] code;
    logic [1:0] sel;
    logic       dflt;
    logic       err;
    int         errcnt;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  cast_code_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_code     (in_code),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_sel     (out_sel),
    .out_default (out_default),
    .out_err     (out_err),
    .out_ready   (out_ready),
    .err_count   (err_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference decode: WIDTH=4 truncations are 10, 12, 45%16=13, 33%16=1, 16%16=0.
  function automatic logic [3:0] model_decode(input logic [3:0] code);
    int k [4];
    k[0] = 10 % 16; k[1] = 12 % 16; k[2] = 45 % 16; k[3] = 33 % 16;
    for (int i = 0; i < 4; i++)
      if (int'(code) == k[i]) return {i[1:0], 2'b00};
    if (int'(code) == 16 % 16) return 4'b0010;
    return 4'b0001;
  endfunction

  // Scoreboard: expected entries queued at push handshake, compared at pop handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_unexpected_pop: got entry %0h expected none", {out_sel, out_default, out_err});
        end else begin
          check("sb_entry", {out_sel, out_default, out_err}, sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        n_pushes++;
        sb.push_back(model_decode(in_code));
        if (model_decode(in_code) == 4'b0001 && model_err < 255) model_err++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int p0;
    int q0;
    vecs[0] = '{4'd10, 2'd0, 1'b0, 1'b0, 0};
    vecs[1] = '{4'd12, 2'd1, 1'b0, 1'b0, 0};
    vecs[2] = '{4'd13, 2'd2, 1'b0, 1'b0, 0};
    vecs[3] = '{4'd1,  2'd3, 1'b0, 1'b0, 0};
    vecs[4] = '{4'd0,  2'd0, 1'b1, 1'b0, 0};
    vecs[5] = '{4'd5,  2'd0, 1'b0, 1'b1, 1};
    vecs[6] = '{4'd15, 2'd0, 1'b0, 1'b1, 2};
    vecs[7] = '{4'd7,  2'd0, 1'b0, 1'b1, 3};

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err_count", err_count, 0);
    check("rst_fields", {out_sel, out_default, out_err}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven decode with 1-cycle latency
    tick();
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_code = vecs[i].code;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_out_valid", out_valid, 1);
      check("vec_fields", {out_sel, out_default, out_err}, {vecs[i].sel, vecs[i].dflt, vecs[i].err});
      check("vec_err_count", err_count, vecs[i].errcnt);
      tick();
    end

    // Full FIFO refuses a 5th offer, then drains in order
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_code = vecs[i].code;
      tick();
    end
    in_code = 4'd0;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    tick(); tick();
    in_valid = 1'b0;
    p0 = n_pops;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    check("full_drain_pops", n_pops - p0, 4);
    check("full_drain_empty", out_valid, 0);
    check("full_sb_empty", sb.size(), 0);

    // Steady throughput from full, across pointer wrap
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_code = 4'((i * 3) % 16);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("thr_full_in_ready", in_ready, 0);
    tick();
    q0 = n_pushes;
    for (int j = 0; j < 10; j++) begin
      in_code = 4'(j + 2);
      @(negedge clk);
      check("thr_in_ready", in_ready, 1);
      check("thr_out_valid", out_valid, 1);
      tick();
    end
    in_valid = 1'b0;
    check("thr_push_count", n_pushes - q0, 10);
    for (int i = 0; i < 6; i++) tick();
    check("thr_sb_empty", sb.size(), 0);

    // err_count saturation
    in_valid = 1'b1; in_code = 4'd5;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    tick(); tick();
    check("sat_err_count", err_count, 255);
    check("sat_model", err_count, model_err);

    // Mid-stream reset discards buffered entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 4'd5;  tick();
    in_code = 4'd10; tick();
    in_code = 4'd13; tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_fields", {out_sel, out_default, out_err}, 0);
    sb.delete();
    model_err = 0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_code = 4'd12;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_sel", out_sel, 1);
    tick(); tick();
    check("post_rst_sb_empty", sb.size(), 0);
    check("post_rst_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
